pong_pixel_gen: RTL and testbench
=================================

Name: pong_pixel_gen

Overview:
- Pixel source for the Pong display path. Sits directly upstream of the VGA timing/driver stage.
- Consumes the driver's pixel_xpos/pixel_ypos request coordinates and its vga_vs. Returns registered 24-bit pixel_data.
- Owns all game state: ball, two paddles, scores, and the serve/play/over state machine.
- Game state updates once per frame, at the start of vertical sync, so visible frames never tear.

Parameters:
- H_DISP, 640, active width in pixels
- V_DISP, 480, active height in pixels
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- PADDLE_XL, 16, left paddle left edge x
- PADDLE_XR, 616, right paddle left edge x
- BALL_SIZE, 8, ball square side
- BALL_STEP, 2, ball pixels per frame on each axis
- PADDLE_STEP, 4, paddle pixels per frame
- SERVE_FRAMES, 60, frames the ball is held centred before play
- WIN_SCORE, 9, score that ends the game
- COL_BG / COL_FG / COL_BALL, 24'h000000 / 24'hFFFFFF / 24'hFFFF00, colours

Ports:
- vga_clk  in  1  pixel clock, the only clock
- sys_rst_n  in  1  synchronous active-low reset
- pixel_xpos  in  10  requested x from the driver
- pixel_ypos  in  10  requested y from the driver
- vga_vs  in  1  vertical sync from the driver, active low
- key_lu, key_ld, key_ru, key_rd  in  1 each  paddle up/down, active high, already debounced
- key_start  in  1  restart after game over, active high
- pixel_data  out  24  colour for the requested pixel
- score_l, score_r  out  4 each  current scores
- game_over  out  1  high in OVER state

Behaviour:
- Reset: sys_rst_n is sampled on vga_clk only; it is synchronous and active-low. When low at a clock edge:
  - pixel_data=0, score_l=score_r=0, game_over=0
  - paddles y=(V_DISP-PADDLE_H)/2=208
  - ball at (H_DISP/2-BALL_SIZE/2, V_DISP/2-BALL_SIZE/2)=(316,236), dx=right, dy=down
  - state=SERVE, serve counter=0, vs_d=1
- Reset asserted mid-game overrides everything on that edge.
- Frame tick: vs_d registers vga_vs each cycle. tick = vs_d & ~vga_vs, a one-cycle pulse on the vga_vs falling edge. All game-state updates happen only on tick cycles.
- Paddles (each tick, in every state):
  - up-only key: y -= PADDLE_STEP, clamped at 0
  - down-only key: y += PADDLE_STEP, clamped at V_DISP-PADDLE_H
  - both or neither pressed: hold
- Ball collision checks use pre-update paddle positions.
- FSM SERVE:
  - ball held at centre, counter increments each tick
  - at counter==SERVE_FRAMES-1: counter cleared, go PLAY
- FSM PLAY, per tick:
  - Vertical, dy=down: if ball_y+BALL_SIZE+BALL_STEP >= V_DISP, set ball_y=V_DISP-BALL_SIZE and dy=up; else ball_y += BALL_STEP.
  - Vertical, dy=up: if ball_y <= BALL_STEP, set ball_y=0 and dy=down; else ball_y -= BALL_STEP.
  - Left hit (dx=left): when ball_x >= PADDLE_XL+PADDLE_W, ball_x-BALL_STEP <= PADDLE_XL+PADDLE_W, ball_y+BALL_SIZE > padl_y and ball_y < padl_y+PADDLE_H. Then ball_x=PADDLE_XL+PADDLE_W, dx=right.
  - Left miss: dx=left and ball_x <= BALL_STEP. Then score_r+1.
  - Right hit and right miss are symmetric, using PADDLE_XR and H_DISP. On hit, ball_x=PADDLE_XR-BALL_SIZE.
  - Otherwise ball_x moves BALL_STEP in the direction of dx.
  - Vertical and horizontal rules apply on the same tick.
  - On a miss:
    - ball recentred
    - dx points toward the player who scored
    - dy=down
    - if the new score equals WIN_SCORE, go OVER; else go SERVE
- FSM OVER:
  - game_over=1, ball not drawn, scores frozen
  - key_start is sampled every cycle, not only on tick
  - key_start high: scores cleared, ball recentred, dx=right, go SERVE
- Scores are 4-bit, never exceed WIN_SCORE, and never wrap.
- Pixel path: pixel_data is registered, latency exactly one vga_clk. Colour priority at (x,y):
  1. ball, COL_BALL: state != OVER and the point lies inside the ball square
  2. paddle, COL_FG: inside either paddle rectangle
  3. score blocks, COL_FG: y in 8..15. Left player: x in [32+12k, 39+12k] for k<score_l. Right player: x in [600-12k, 607-12k] for k<score_r.
  4. centre line, COL_FG: x in 319..320 and y[3]==0
  5. otherwise COL_BG
- Coordinates outside 0..H_DISP-1 / 0..V_DISP-1 output COL_BG.

Test Plan:
- Reset, then release, then run 60 ticks -> ball stays at (316,236) for 59 ticks; state PLAY after tick 60; ball at (318,238) after tick 61.
- Hold key_lu for 60 ticks -> left paddle y 208, 204, ... down to 0 and stays 0. Hold key_lu and key_ld together -> y unchanged.
- Place ball at (26,230), dx=left, left paddle y=208 -> next tick ball_x=24, dx=right, score unchanged.
- Left paddle at y=0, ball at (2,400) moving left -> score_r=1, ball at (316,236), dx=right, state SERVE.
- score_l=8 and right miss -> score_l=9, game_over=1, ball pixel absent. key_start pulse -> scores 0, SERVE.
- Drive pixel_xpos=316, pixel_ypos=236 with ball centred -> pixel_data=24'hFFFF00 one cycle later. Drive x=319, y=4 -> 24'hFFFFFF. Drive x=319, y=8 -> 24'h000000.

Source files
------------

// File: rtl/pong_pixel_gen_if.sv
// Pixel request/response bundle between the VGA timing driver (master) and the Pong pixel source.
interface pong_pixel_gen_if;
  logic [9:0]  pixel_xpos;
  logic [9:0]  pixel_ypos;
  logic        vga_vs;
  logic [23:0] pixel_data;

  modport master (
    output pixel_xpos,
    output pixel_ypos,
    output vga_vs,
    input  pixel_data
  );

  modport slave (
    input  pixel_xpos,
    input  pixel_ypos,
    input  vga_vs,
    output pixel_data
  );
endinterface

// File: rtl/pong_pixel_gen.sv
// Pong pixel source: owns ball, paddles, scores and serve/play/over FSM, updated once per frame
// on the vga_vs falling edge; returns the registered colour of the requested pixel.
module pong_pixel_gen #(
  parameter int unsigned H_DISP       = 640,
  parameter int unsigned V_DISP       = 480,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_XL    = 16,
  parameter int unsigned PADDLE_XR    = 616,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned BALL_STEP    = 2,
  parameter int unsigned PADDLE_STEP  = 4,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 9,
  parameter logic [23:0] COL_BG       = 24'h000000,
  parameter logic [23:0] COL_FG       = 24'hFFFFFF,
  parameter logic [23:0] COL_BALL     = 24'hFFFF00
) (
  input  logic                   vga_clk,
  input  logic                   sys_rst_n,
  pong_pixel_gen_if.slave        vga,
  input  logic                   key_lu,
  input  logic                   key_ld,
  input  logic                   key_ru,
  input  logic                   key_rd,
  input  logic                   key_start,
  output logic [3:0]             score_l,
  output logic [3:0]             score_r,
  output logic                   game_over
);

  typedef logic [10:0] coord_t;
  typedef enum logic [1:0] {StServe, StPlay, StOver} state_e;

  localparam int unsigned CntW = $clog2(SERVE_FRAMES + 1);

  localparam coord_t HDisp    = coord_t'(H_DISP);
  localparam coord_t VDisp    = coord_t'(V_DISP);
  localparam coord_t PadW     = coord_t'(PADDLE_W);
  localparam coord_t PadH     = coord_t'(PADDLE_H);
  localparam coord_t PadXl    = coord_t'(PADDLE_XL);
  localparam coord_t PadXr    = coord_t'(PADDLE_XR);
  localparam coord_t BallSz   = coord_t'(BALL_SIZE);
  localparam coord_t BallStep = coord_t'(BALL_STEP);
  localparam coord_t PadStep  = coord_t'(PADDLE_STEP);
  localparam coord_t PadY0    = coord_t'((V_DISP - PADDLE_H) / 2);
  localparam coord_t PadYMax  = coord_t'(V_DISP - PADDLE_H);
  localparam coord_t BallX0   = coord_t'(H_DISP / 2 - BALL_SIZE / 2);
  localparam coord_t BallY0   = coord_t'(V_DISP / 2 - BALL_SIZE / 2);
  localparam coord_t LineX0   = coord_t'(H_DISP / 2 - 1);
  localparam coord_t LineX1   = coord_t'(H_DISP / 2);
  localparam coord_t ScoreY0  = coord_t'(8);
  localparam coord_t ScoreY1  = coord_t'(15);
  localparam logic [3:0]      WinScore  = 4'(WIN_SCORE);
  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_FRAMES - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] serve_cnt_q, serve_cnt_d;
  coord_t          pad_l_q, pad_l_d, pad_r_q, pad_r_d;
  coord_t          ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic            dir_x_q, dir_x_d;  // 1: moving right
  logic            dir_y_q, dir_y_d;  // 1: moving down
  logic [3:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic            vs_q;
  logic [23:0]     pixel_q, pixel_d;
  logic            tick;
  logic            hit_l, hit_r, miss_l, miss_r;
  coord_t          px, py;

  function automatic coord_t pad_next(coord_t y, logic up, logic dn);
    if (up && !dn) return (y <= PadStep) ? '0 : y - PadStep;
    if (dn && !up) return (y + PadStep >= PadYMax) ? PadYMax : y + PadStep;
    return y;
  endfunction

  assign tick = vs_q & ~vga.vga_vs;

  // Collision tests deliberately use the paddle positions from before this tick.
  assign hit_l  = !dir_x_q && (ball_x_q >= PadXl + PadW) && (ball_x_q - BallStep <= PadXl + PadW) &&
                  (ball_y_q + BallSz > pad_l_q) && (ball_y_q < pad_l_q + PadH);
  assign hit_r  = dir_x_q && (ball_x_q + BallSz <= PadXr) &&
                  (ball_x_q + BallSz + BallStep >= PadXr) &&
                  (ball_y_q + BallSz > pad_r_q) && (ball_y_q < pad_r_q + PadH);
  assign miss_l = !dir_x_q && (ball_x_q <= BallStep);
  assign miss_r = dir_x_q && (ball_x_q + BallSz + BallStep >= HDisp);

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    pad_l_d     = pad_l_q;
    pad_r_d     = pad_r_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    score_l_d   = score_l_q;
    score_r_d   = score_r_q;
    if (tick) begin
      pad_l_d = pad_next(pad_l_q, key_lu, key_ld);
      pad_r_d = pad_next(pad_r_q, key_ru, key_rd);
      case (state_q)
        StServe: begin
          ball_x_d = BallX0;
          ball_y_d = BallY0;
          if (serve_cnt_q == ServeLast) begin
            serve_cnt_d = '0;
            state_d     = StPlay;
          end else begin
            serve_cnt_d = serve_cnt_q + 1'b1;
          end
        end
        StPlay: begin
          if (dir_y_q) begin
            if (ball_y_q + BallSz + BallStep >= VDisp) begin
              ball_y_d = VDisp - BallSz;
              dir_y_d  = 1'b0;
            end else begin
              ball_y_d = ball_y_q + BallStep;
            end
          end else if (ball_y_q <= BallStep) begin
            ball_y_d = '0;
            dir_y_d  = 1'b1;
          end else begin
            ball_y_d = ball_y_q - BallStep;
          end
          if (hit_l) begin
            ball_x_d = PadXl + PadW;
            dir_x_d  = 1'b1;
          end else if (hit_r) begin
            ball_x_d = PadXr - BallSz;
            dir_x_d  = 1'b0;
          end else if (miss_l || miss_r) begin
            ball_x_d = BallX0;
            ball_y_d = BallY0;
            dir_x_d  = miss_l;  // serve toward the player who just scored
            dir_y_d  = 1'b1;
            if (miss_l) begin
              score_r_d = score_r_q + 4'd1;
              state_d   = (score_r_d == WinScore) ? StOver : StServe;
            end else begin
              score_l_d = score_l_q + 4'd1;
              state_d   = (score_l_d == WinScore) ? StOver : StServe;
            end
          end else begin
            ball_x_d = dir_x_q ? ball_x_q + BallStep : ball_x_q - BallStep;
          end
        end
        default: ;
      endcase
    end
    if (state_q == StOver && key_start) begin
      score_l_d   = '0;
      score_r_d   = '0;
      ball_x_d    = BallX0;
      ball_y_d    = BallY0;
      dir_x_d     = 1'b1;
      dir_y_d     = 1'b1;
      serve_cnt_d = '0;
      state_d     = StServe;
    end
  end

  assign px = {1'b0, vga.pixel_xpos};
  assign py = {1'b0, vga.pixel_ypos};

  always_comb begin
    logic in_ball, in_pad, in_score, in_line;
    in_ball  = (state_q != StOver) && (px >= ball_x_q) && (px < ball_x_q + BallSz) &&
               (py >= ball_y_q) && (py < ball_y_q + BallSz);
    in_pad   = ((px >= PadXl) && (px < PadXl + PadW) && (py >= pad_l_q) && (py < pad_l_q + PadH)) ||
               ((px >= PadXr) && (px < PadXr + PadW) && (py >= pad_r_q) && (py < pad_r_q + PadH));
    in_score = 1'b0;
    if (py >= ScoreY0 && py <= ScoreY1) begin
      for (int k = 0; k < int'(WIN_SCORE); k++) begin
        if (4'(k) < score_l_q && px >= coord_t'(32 + 12 * k) && px <= coord_t'(39 + 12 * k)) begin
          in_score = 1'b1;
        end
        if (4'(k) < score_r_q && px >= coord_t'(600 - 12 * k) && px <= coord_t'(607 - 12 * k)) begin
          in_score = 1'b1;
        end
      end
    end
    in_line = (px == LineX0 || px == LineX1) && !py[3];
    if (px >= HDisp || py >= VDisp) pixel_d = COL_BG;
    else if (in_ball)               pixel_d = COL_BALL;
    else if (in_pad || in_score || in_line) pixel_d = COL_FG;
    else                            pixel_d = COL_BG;
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state_q     <= StServe;
      serve_cnt_q <= '0;
      pad_l_q     <= PadY0;
      pad_r_q     <= PadY0;
      ball_x_q    <= BallX0;
      ball_y_q    <= BallY0;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      score_l_q   <= '0;
      score_r_q   <= '0;
      vs_q        <= 1'b1;
      pixel_q     <= '0;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      pad_l_q     <= pad_l_d;
      pad_r_q     <= pad_r_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      vs_q        <= vga.vga_vs;
      pixel_q     <= pixel_d;
    end
  end

  assign vga.pixel_data = pixel_q;
  assign score_l        = score_l_q;
  assign score_r        = score_r_q;
  assign game_over      = (state_q == StOver);

endmodule

// File: tb/tb_pong_pixel_gen.sv
// Directed bench for pong_pixel_gen: a pixel vector table plus whole-game sequences driven by vsync.
module tb_pong_pixel_gen;

  localparam logic [23:0] Bg  = 24'h000000;
  localparam logic [23:0] Fg  = 24'hFFFFFF;
  localparam logic [23:0] Yel = 24'hFFFF00;
  localparam int NVec = 22;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] exp;
  } pix_vec_t;

  logic       vga_clk = 1'b0;
  logic       sys_rst_n;
  logic       key_lu, key_ld, key_ru, key_rd, key_start;
  logic [3:0] score_l, score_r;
  logic       game_over;
  int         n_cmp = 0;
  int         n_bad = 0;
  pix_vec_t   vecs[NVec];

  always #5 vga_clk = ~vga_clk;

  pong_pixel_gen_if vga ();

  pong_pixel_gen dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .vga       (vga),
    .key_lu    (key_lu),
    .key_ld    (key_ld),
    .key_ru    (key_ru),
    .key_rd    (key_rd),
    .key_start (key_start),
    .score_l   (score_l),
    .score_r   (score_r),
    .game_over (game_over)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic probe(input logic [9:0] x, input logic [9:0] y, input logic [23:0] exp,
                       input string name);
    vga.pixel_xpos = x;
    vga.pixel_ypos = y;
    @(posedge vga_clk);
    #1;
    check(name, 32'(vga.pixel_data), 32'(exp));
  endtask

  // One vga_vs falling edge, i.e. one game tick.
  task automatic do_tick();
    vga.vga_vs = 1'b0;
    @(posedge vga_clk);
    #1;
    vga.vga_vs = 1'b1;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic wait_point(input int exp_ticks, input logic [3:0] el, input logic [3:0] er,
                            input string name);
    int cnt = 0;
    logic [3:0] l0 = score_l;
    logic [3:0] r0 = score_r;
    while (score_l == l0 && score_r == r0 && cnt < 2000) begin
      do_tick();
      cnt++;
    end
    check({name, " ticks"}, 32'(cnt), 32'(exp_ticks));
    check({name, " score_l"}, 32'(score_l), 32'(el));
    check({name, " score_r"}, 32'(score_r), 32'(er));
  endtask

  initial begin
    vecs[0]  = '{10'd316, 10'd236, Yel};
    vecs[1]  = '{10'd323, 10'd243, Yel};
    vecs[2]  = '{10'd324, 10'd243, Bg};
    vecs[3]  = '{10'd315, 10'd236, Bg};
    vecs[4]  = '{10'd319, 10'd236, Yel};
    vecs[5]  = '{10'd319, 10'd4,   Fg};
    vecs[6]  = '{10'd319, 10'd8,   Bg};
    vecs[7]  = '{10'd320, 10'd0,   Fg};
    vecs[8]  = '{10'd321, 10'd0,   Bg};
    vecs[9]  = '{10'd318, 10'd0,   Bg};
    vecs[10] = '{10'd16,  10'd208, Fg};
    vecs[11] = '{10'd23,  10'd271, Fg};
    vecs[12] = '{10'd24,  10'd240, Bg};
    vecs[13] = '{10'd16,  10'd272, Bg};
    vecs[14] = '{10'd15,  10'd208, Bg};
    vecs[15] = '{10'd616, 10'd208, Fg};
    vecs[16] = '{10'd623, 10'd271, Fg};
    vecs[17] = '{10'd616, 10'd207, Bg};
    vecs[18] = '{10'd640, 10'd0,   Bg};
    vecs[19] = '{10'd319, 10'd480, Bg};
    vecs[20] = '{10'd32,  10'd8,   Bg};
    vecs[21] = '{10'd600, 10'd8,   Bg};

    sys_rst_n = 1'b0;
    {key_lu, key_ld, key_ru, key_rd, key_start} = '0;
    vga.vga_vs = 1'b1;
    vga.pixel_xpos = 10'd16;
    vga.pixel_ypos = 10'd208;
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset pixel", 32'(vga.pixel_data), 32'(Bg));
    check("reset score_l", 32'(score_l), 0);
    check("reset score_r", 32'(score_r), 0);
    check("reset game_over", 32'(game_over), 0);
    sys_rst_n = 1'b1;

    for (int i = 0; i < NVec; i++) probe(vecs[i].x, vecs[i].y, vecs[i].exp, $sformatf("vec%0d", i));

    // Serve hold, then first move
    ticks(59);
    probe(10'd316, 10'd236, Yel, "serve59 ball");
    probe(10'd323, 10'd243, Yel, "serve59 ball corner");
    ticks(1);
    probe(10'd316, 10'd236, Yel, "serve60 ball");
    ticks(1);
    probe(10'd318, 10'd238, Yel, "play1 ball");
    probe(10'd325, 10'd245, Yel, "play1 ball corner");
    probe(10'd317, 10'd238, Bg, "play1 old left edge");
    probe(10'd326, 10'd238, Bg, "play1 right of ball");

    // Left paddle up to the top clamp, then both keys hold
    key_lu = 1'b1;
    ticks(1);
    probe(10'd16, 10'd204, Fg, "padl 204 top");
    probe(10'd16, 10'd203, Bg, "padl above");
    probe(10'd16, 10'd267, Fg, "padl 204 bottom");
    probe(10'd16, 10'd268, Bg, "padl below");
    ticks(59);
    probe(10'd16, 10'd0, Fg, "padl clamp top");
    probe(10'd23, 10'd63, Fg, "padl clamp bottom");
    probe(10'd16, 10'd64, Bg, "padl clamp below");
    key_ld = 1'b1;
    ticks(5);
    probe(10'd16, 10'd0, Fg, "padl both keys top");
    probe(10'd16, 10'd64, Bg, "padl both keys below");
    key_lu = 1'b0;
    key_ld = 1'b0;

    // Rally 1: right paddle misses; rally 2: left paddle at top misses
    wait_point(92, 4'd1, 4'd0, "rally1");
    wait_point(218, 4'd1, 4'd1, "rally2");
    check("rally2 game_over", 32'(game_over), 0);
    probe(10'd316, 10'd236, Yel, "rally2 recentred");
    key_ld = 1'b1;
    ticks(61);
    probe(10'd318, 10'd238, Yel, "rally3 serves right");
    wait_point(157, 4'd2, 4'd1, "rally3");

    // Rally 4: left paddle at the bottom clamp returns the ball
    ticks(206);
    probe(10'd24, 10'd416, Yel, "lhit ball at edge");
    ticks(1);
    probe(10'd26, 10'd414, Yel, "lhit bounced right");
    probe(10'd25, 10'd414, Bg, "lhit not passed");
    check("lhit score_l", 32'(score_l), 2);
    wait_point(303, 4'd3, 4'd1, "rally4");
    for (int s = 4; s <= 9; s++) begin
      wait_point(510, 4'(s), 4'd1, $sformatf("rally%0d", s + 1));
      check($sformatf("game_over at %0d", s), 32'(game_over), 32'(s == 9));
    end

    // Game over: ball hidden, score blocks drawn
    probe(10'd316, 10'd236, Bg, "over ball hidden");
    probe(10'd32,  10'd8,  Fg, "scl k0 left");
    probe(10'd39,  10'd15, Fg, "scl k0 right");
    probe(10'd128, 10'd8,  Fg, "scl k8 left");
    probe(10'd135, 10'd15, Fg, "scl k8 right");
    probe(10'd136, 10'd8,  Bg, "scl gap");
    probe(10'd140, 10'd8,  Bg, "scl k9 absent");
    probe(10'd600, 10'd8,  Fg, "scr k0 left");
    probe(10'd607, 10'd15, Fg, "scr k0 right");
    probe(10'd599, 10'd8,  Bg, "scr left of k0");
    probe(10'd588, 10'd8,  Bg, "scr k1 absent");
    probe(10'd600, 10'd16, Bg, "scr below rows");
    probe(10'd600, 10'd7,  Bg, "scr above rows");
    ticks(3);
    check("over frozen score_l", 32'(score_l), 9);
    check("over frozen score_r", 32'(score_r), 1);
    check("over stays", 32'(game_over), 1);

    // Restart on a single-cycle key_start outside any tick
    key_start = 1'b1;
    @(posedge vga_clk);
    #1;
    key_start = 1'b0;
    check("restart score_l", 32'(score_l), 0);
    check("restart score_r", 32'(score_r), 0);
    check("restart game_over", 32'(game_over), 0);
    probe(10'd316, 10'd236, Yel, "restart ball centred");
    ticks(61);
    probe(10'd318, 10'd238, Yel, "restart play1 ball");

    // Reset in mid-play
    vga.pixel_xpos = 10'd318;
    vga.pixel_ypos = 10'd238;
    sys_rst_n = 1'b0;
    @(posedge vga_clk);
    #1;
    check("midreset pixel", 32'(vga.pixel_data), 32'(Bg));
    sys_rst_n = 1'b1;
    key_ld = 1'b0;
    probe(10'd316, 10'd236, Yel, "midreset ball centred");
    probe(10'd16, 10'd208, Fg, "midreset padl");
    probe(10'd16, 10'd416, Bg, "midreset padl old");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
